// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access in the pipelined MIPS core.
// Data accesses win ties. Returned words are held until the pipeline advances.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pipe_stall,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                bus_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arbState;

    arbState state;
    arbState stateNext;

    logic              ifDone;
    logic              dmDone;
    logic              ifStallInt;
    logic              dmStallInt;
    logic              advance;
    logic              busy;
    logic              ackSeen;
    logic              timedOut;
    logic              finish;
    logic              startIf;
    logic              startDm;
    logic [CNT_W-1:0]  waitCnt;
    logic              memWeReg;
    logic [BE_W-1:0]   memBeReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWdataReg;
    logic [DATA_W-1:0] ifRdataReg;
    logic [DATA_W-1:0] dmRdataReg;
    logic              busErrReg;

    // A done flag masks its request until the pipeline moves on, which is what
    // prevents a stalled store from being written twice.
    assign ifStallInt = if_req & ~ifDone;
    assign dmStallInt = dm_req & ~dmDone;
    assign advance    = ~pipe_stall & ~ifStallInt & ~dmStallInt;

    assign busy     = (state != IDLE);
    assign ackSeen  = busy & mem_ack;
    assign timedOut = busy & ~mem_ack & (waitCnt == LAST_WAIT);
    assign finish   = ackSeen | timedOut;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        startIf   = 1'b0;
        startDm   = 1'b0;
        case (state)
            IDLE: begin
                if (dmStallInt) begin
                    stateNext = BUSY_DM;
                    startDm   = 1'b1;
                end else if (ifStallInt) begin
                    stateNext = BUSY_IF;
                    startIf   = 1'b1;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (finish) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Transaction fields are latched once at the start and held until completion,
    // so requester changes during a wait never reach the memory.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            memWeReg    <= 1'b0;
            memBeReg    <= '0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            waitCnt     <= '0;
        end else begin
            if (startDm) begin
                memWeReg    <= dm_we;
                memBeReg    <= dm_we ? dm_be : '1;
                memAddrReg  <= dm_addr;
                memWdataReg <= dm_wdata;
            end else if (startIf) begin
                memWeReg    <= 1'b0;
                memBeReg    <= '1;
                memAddrReg  <= if_addr;
                memWdataReg <= '0;
            end else if (finish) begin
                memWeReg    <= 1'b0;
            end
            waitCnt <= (busy && !finish) ? waitCnt + CNT_W'(1) : '0;
        end
    end

    // Completion (ack or timeout) outranks an advance in the same cycle; the flag
    // then clears on the following advance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ifDone <= 1'b0;
            dmDone <= 1'b0;
        end else begin
            if (state == BUSY_IF && finish) begin
                ifDone <= 1'b1;
            end else if (advance) begin
                ifDone <= 1'b0;
            end
            if (state == BUSY_DM && finish) begin
                dmDone <= 1'b1;
            end else if (advance) begin
                dmDone <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ifRdataReg <= '0;
            dmRdataReg <= '0;
            busErrReg  <= 1'b0;
        end else begin
            if (state == BUSY_IF) begin
                if (ackSeen) begin
                    ifRdataReg <= mem_rdata;
                end else if (timedOut) begin
                    ifRdataReg <= '0;
                end
            end
            if (state == BUSY_DM) begin
                if (ackSeen && !memWeReg) begin
                    dmRdataReg <= mem_rdata;
                end else if (timedOut) begin
                    dmRdataReg <= '0;
                end
            end
            if (timedOut) begin
                busErrReg <= 1'b1;
            end
        end
    end

    assign if_stall  = ifStallInt;
    assign dm_stall  = dmStallInt;
    assign if_rdata  = ifRdataReg;
    assign dm_rdata  = dmRdataReg;
    assign mem_req   = busy;
    assign mem_we    = memWeReg;
    assign mem_be    = memBeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign bus_err   = busErrReg;

endmodule
